// File: rtl/shift_seq_pkg.sv
// Shared encodings and helpers for the shift sequencer and its serializer.
package shift_seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } state_e;

  // Requested lengths above the register width are clamped to the width.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    int unsigned r;
    if (len > max_len) begin
      r = max_len;
    end else begin
      r = len;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_seq_ser.sv
// Load/shift-right pattern buffer; bit 0 is the bit on the wire, bit 1 the one after it.
module shift_seq_ser #(
  parameter int MSB = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [MSB-1:0] load_data,
  output logic           lsb,
  output logic           lsb_next
);

  logic [MSB-1:0] buf_q;
  logic [MSB-1:0] buf_d;

  // Next buffer value: load wins over step, zero fill on step.
  always_comb begin
    buf_d = buf_q;
    if (load) begin
      buf_d = load_data;
    end else if (step) begin
      buf_d = {1'b0, buf_q[MSB-1:1]};
    end else begin
      buf_d = buf_q;
    end
  end

  // Buffer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= {MSB{1'b0}};
    end else begin
      buf_q <= buf_d;
    end
  end

  assign lsb      = buf_q[0];
  assign lsb_next = buf_q[1];

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven controller serializing a pattern onto a bidirectional shift register.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int MSB   = 16,
  parameter int LEN_W = $clog2(MSB + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [MSB-1:0]   cmd_data,
  input  logic             hold,
  input  logic             abort,
  output logic             sr_en,
  output logic             sr_dir,
  output logic             sr_d,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [LEN_W-1:0] bit_cnt
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               sr_en_q, sr_en_d;
  logic               sr_dir_q, sr_dir_d;
  logic               sr_d_q, sr_d_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;
  logic               load_s;
  logic               step_s;
  logic               ser_lsb_s;
  logic               ser_lsb_next_s;
  logic [LEN_W-1:0]   len_eff_s;

  assign len_eff_s = LEN_W'(clamp_len(32'(cmd_len), MSB));

  shift_seq_ser #(.MSB(MSB)) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .step      (step_s),
    .load_data (cmd_data),
    .lsb       (ser_lsb_s),
    .lsb_next  (ser_lsb_next_s)
  );

  // Next state, counter and buffer control. The buffer advances exactly on the
  // cycles where sr_en is high, so the register and the buffer never disagree.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    bit_cnt_d = bit_cnt_q;
    sr_dir_d  = sr_dir_q;
    aborted_d = 1'b0;
    load_s    = 1'b0;
    step_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          load_s    = 1'b1;
          len_d     = len_eff_s;
          sr_dir_d  = cmd_dir;
          bit_cnt_d = {LEN_W{1'b0}};
          state_d   = (len_eff_s == {LEN_W{1'b0}}) ? S_DONE : S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (sr_en_q) begin
          step_s    = 1'b1;
          bit_cnt_d = bit_cnt_q + LEN_W'(1);
          state_d   = (bit_cnt_q == (len_q - LEN_W'(1))) ? S_DONE : S_SHIFT;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs derived from the upcoming state; hold only gates SHIFT-to-SHIFT cycles.
  always_comb begin
    sr_en_d     = (state_d == S_SHIFT) && ((state_q != S_SHIFT) || !hold);
    sr_d_d      = 1'b0;
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    if (state_d == S_SHIFT) begin
      sr_d_d = load_s ? cmd_data[0] : (step_s ? ser_lsb_next_s : ser_lsb_s);
    end else begin
      sr_d_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= {LEN_W{1'b0}};
      bit_cnt_q   <= {LEN_W{1'b0}};
      cmd_ready_q <= 1'b1;
      sr_en_q     <= 1'b0;
      sr_dir_q    <= DIR_UP;
      sr_d_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_ready_q <= cmd_ready_d;
      sr_en_q     <= sr_en_d;
      sr_dir_q    <= sr_dir_d;
      sr_d_q      <= sr_d_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign sr_en     = sr_en_q;
  assign sr_dir    = sr_dir_q;
  assign sr_d      = sr_d_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign bit_cnt   = bit_cnt_q;

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Command-driven controller for a bidirectional shift register; it drives the register's enable, direction and serial-data pins.
- Accepts one command at a time over a valid/ready handshake. A command carries a direction, a bit count and a data pattern.
- Serializes the pattern onto the register's data pin for exactly the commanded number of clocks, then pulses done.
- Sits between the bus/config logic and the shift register instance.

Parameters:
- MSB, 16, shift register width; also the maximum bits per command.
- LEN_W, $clog2(MSB+1), width of the length field and the bit counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_dir  input  1  0 = shift toward MSB, 1 = shift toward LSB; passed to sr_dir.
- cmd_len  input  LEN_W  number of bits to shift (0..MSB).
- cmd_data  input  MSB  pattern to serialize, bit 0 first.
- hold  input  1  stall the shift, state frozen.
- abort  input  1  terminate the current command.
- sr_en  output  1  shift register enable.
- sr_dir  output  1  shift register direction.
- sr_d  output  1  shift register serial data.
- busy  output  1  command in progress (SHIFT or DONE).
- done  output  1  one-cycle pulse on normal completion.
- aborted  output  1  one-cycle pulse when a command is aborted.
- bit_cnt  output  LEN_W  bits shifted so far in the current command.

Behaviour:
- All outputs are registered. On rst, asynchronously: state=IDLE, cmd_ready=1, sr_en=0, sr_dir=0, sr_d=0, busy=0, done=0, aborted=0, bit_cnt=0, internal shift buffer=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - cmd_ready=1.
  - Accept on the edge where cmd_valid && cmd_ready: latch cmd_data into the buffer, latch cmd_dir and the effective length.
  - Effective length = min(cmd_len, MSB).
  - If the effective length is 0, go to DONE with no sr_en cycle. Otherwise go to SHIFT.
- SHIFT:
  - cmd_ready=0, busy=1, sr_dir = latched direction.
  - sr_d = buffer[0] and sr_en = !hold, both valid in the same cycle.
  - On each edge with hold=0: shift the buffer right by 1 (zero fill) and increment bit_cnt.
  - When bit_cnt reaches len-1 on a non-held edge, the next state is DONE.
- DONE:
  - Lasts one cycle with done=1, sr_en=0, busy=1.
  - Then IDLE with cmd_ready=1. bit_cnt holds its final value until the next accept, which clears it to 0.
- Latency (no hold): command accepted at edge k. sr_en is high in cycles k+1..k+len, done is high in cycle k+len+1, and cmd_ready is high again from cycle k+len+2.
- hold:
  - Lowers sr_en combinationally-registered on the next cycle boundary. No buffer or counter update while held.
  - In IDLE and DONE, hold has no effect.
  - Extends latency by exactly the number of held SHIFT cycles.
- abort:
  - Sampled in SHIFT only; it has priority over hold and over completion on the same edge.
  - Next cycle: state=IDLE, sr_en=0, aborted=1 for one cycle, done never asserted, bit_cnt keeps the count reached.
  - abort in IDLE or DONE is ignored.
- sr_dir changes only at accept. It is stable for the whole command and retains its last value in IDLE.
- sr_d=0 whenever sr_en=0 outside SHIFT.
- rst asserted mid-command: immediate return to reset values; no done or aborted pulse.

Decomposition:
- Package shift_seq_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - Direction constants DIR_UP=1'b0, DIR_DOWN=1'b1.
- One sub-module, shift_seq_ser: the MSB-wide load/shift-right buffer with a load/step interface, exposing bit 0.
- The FSM, counter and handshake stay in shift_sequencer.
- The bench pairs the block with the team's bidirectional shift register model: dir=0 inserts d at bit 0 and moves toward MSB.

Test Plan:
- Reset then one command (MSB=16, cmd_data=16'h00B5, len=8, dir=0).
  - sr_d over 8 sr_en cycles = 1,0,1,0,1,1,0,1.
  - done exactly 1 cycle later; register out[7:0]=8'hAD.
- len=0 command -> no sr_en cycle; done in the cycle after accept; cmd_ready back the cycle after that.
- len=20 with MSB=16 -> clamped: exactly 16 sr_en cycles, bit_cnt final=16, done once.
- hold asserted for 3 cycles mid-command (len=8) -> sr_en low for those 3 cycles, sr_d frozen, done 3 cycles later than nominal, sr_d sequence unchanged.
- abort after 4 bits (len=8) -> aborted pulse, no done, bit_cnt=4, cmd_ready high the next cycle.
- Back-to-back commands (dir=0 then dir=1, cmd_valid held high).
  - Second command accepted only when cmd_ready=1.
  - sr_dir switches only at the second accept.
  - rst pulse during the second command -> all outputs return to reset values immediately.
